// File: rtl/PARAMS_pkg.sv
// Shared core parameters plus the types used by the fetch stage.
// The stage FSM, the queue entry layout and word alignment live here so decode can reuse them.
package PARAMS_pkg;

    localparam int INSTR_SIZE = 32;
    localparam logic [INSTR_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_SIZE-1:0] pc;
        logic [INSTR_SIZE-1:0] instr;
    } fetch_entry_t;

    function automatic logic [INSTR_SIZE-1:0] align_word(input logic [INSTR_SIZE-1:0] addr);
        return {addr[INSTR_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO holding fetched {pc, instr} pairs.
// Flush wins over push and pop; the caller guarantees push never targets a full queue.
module fetch_queue #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             rd_ptr_d;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             wr_ptr;

    // Write slot is the one after the last valid entry; with two entries it is the head slot being popped.
    assign wr_ptr  = rd_ptr_q ^ count_q[0];
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
        rd_ptr_d = pop_i ? ~rd_ptr_q : rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/stage_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// buffers responses in a 2-entry queue and presents the head to decode.
module stage_fetch
    import PARAMS_pkg::*;
#(
    parameter logic [INSTR_SIZE-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_req_o,
    output logic [INSTR_SIZE-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [INSTR_SIZE-1:0] imem_rdata_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [INSTR_SIZE-1:0] redirect_pc_i,
    output logic [INSTR_SIZE-1:0] instr_o,
    output logic [INSTR_SIZE-1:0] pc_o,
    output logic                  instr_valid_o
);

    fetch_state_t          fsm_q;
    fetch_state_t          fsm_d;
    logic [INSTR_SIZE-1:0] pc_q;
    logic [INSTR_SIZE-1:0] pc_d;
    logic [INSTR_SIZE-1:0] req_pc_q;
    logic [INSTR_SIZE-1:0] req_pc_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [1:0]            count;
    logic [2:0]            count_next;
    fetch_entry_t          push_entry;
    fetch_entry_t          head_entry;

    assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};

    fetch_queue #(
        .WIDTH($bits(fetch_entry_t))
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .data_i  (push_entry),
        .head_o  (head_entry),
        .count_o (count)
    );

    assign instr_valid_o = (count != 2'd0);
    assign instr_o       = instr_valid_o ? head_entry.instr : NOP_INSTR;
    assign pc_o          = instr_valid_o ? head_entry.pc : '0;

    // A new request is only issued if the queue still has a free slot for its response.
    always_comb begin
        pop        = instr_valid_o && !stall_i && !redirect_i;
        push       = (fsm_q == WAIT) && imem_rvalid_i && !redirect_i;
        count_next = {1'b0, count} + {2'b00, push} - {2'b00, pop};
        issue      = reset_n && !redirect_i && (count_next <= 3'd1)
                     && ((fsm_q == FETCH) || ((fsm_q == WAIT) && imem_rvalid_i));
    end

    assign imem_req_o  = issue;
    assign imem_addr_o = pc_q;

    always_comb begin
        fsm_d    = fsm_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect_i) begin
            pc_d = align_word(redirect_pc_i);
            case (fsm_q)
                WAIT, DROP: fsm_d = imem_rvalid_i ? FETCH : DROP;
                default:    fsm_d = FETCH;
            endcase
        end else if (issue) begin
            fsm_d    = WAIT;
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end else if ((fsm_q != FETCH) && imem_rvalid_i) begin
            fsm_d = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm_q    <= FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            fsm_q    <= fsm_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

endmodule

// File: tb/tb_stage_fetch.sv
// Randomized bench for stage_fetch: a latency-L memory, random stalls/redirects/resets,
// and a queue-based reference model of the fetch rules checked every cycle.
module tb_stage_fetch;
    import PARAMS_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;

    always #5 clk = ~clk;

    stage_fetch #(.RESET_PC(TB_RESET_PC)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_valid_o (instr_valid_o)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } memResp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } refEntry_t;

    int          compared = 0;
    int          mismatched = 0;
    int          cycleNo = 0;
    int          latency = 1;
    int          stallPct = 0;
    int          redirPct = 0;
    int          stallLeft = 0;
    bit          forceRedirect = 0;
    logic [31:0] forceTarget = '0;

    memResp_t    memQ[$];
    logic [31:0] reqLog[$];

    refEntry_t   refQ[$];
    logic [31:0] refNextPc;
    logic [31:0] refReqPc;
    bit          refOutstanding;
    bit          refDiscard;
    bit          refKnown = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cycleNo, observed, expected);
        end
    endtask

    // Drive all inputs for the coming cycle just after the falling edge.
    task automatic applyStimulus(input bit assertReset);
        @(negedge clk);
        reset_n = !assertReset;
        if (stallLeft > 0) begin
            stall_i = 1'b1;
            stallLeft--;
        end else if ($urandom_range(0, 99) < stallPct) begin
            stall_i   = 1'b1;
            stallLeft = $urandom_range(0, 6);
        end else begin
            stall_i = 1'b0;
        end
        if (forceRedirect) begin
            redirect_i    = 1'b1;
            redirect_pc_i = forceTarget;
            forceRedirect = 0;
        end else begin
            redirect_i    = !assertReset && ($urandom_range(0, 99) < redirPct);
            redirect_pc_i = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        if (memQ.size() > 0 && memQ[0].due == cycleNo) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memQ[0].data;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
    endtask

    // Compare outputs with the model, then advance model and memory by one cycle.
    task automatic stepModel();
        bit        rv;
        bit        expValid;
        bit        doPop;
        bit        doPush;
        bit        doIssue;
        int        cnt;
        refEntry_t e;
        rv       = imem_rvalid_i;
        expValid = refQ.size() > 0;
        doPop    = expValid && !stall_i && !redirect_i;
        doPush   = refOutstanding && !refDiscard && rv && !redirect_i;
        cnt      = refQ.size() + int'(doPush) - int'(doPop);
        doIssue  = reset_n && !redirect_i && (cnt <= 1) && (!refOutstanding || doPush);

        if (refKnown) begin
            checkOutput("instr_valid", instr_valid_o, expValid);
            checkOutput("instr", instr_o, expValid ? refQ[0].instr : NOP_INSTR);
            checkOutput("pc", pc_o, expValid ? refQ[0].pc : 32'h0);
            checkOutput("imem_req", imem_req_o, doIssue);
            checkOutput("imem_addr", imem_addr_o, refNextPc);
        end

        if (imem_rvalid_i) memQ.pop_front();
        if (imem_req_o === 1'b1) begin
            memQ.push_back('{cycleNo + latency, $urandom});
            reqLog.push_back(imem_addr_o);
        end

        if (!reset_n) begin
            memQ.delete();
            refQ.delete();
            refNextPc      = TB_RESET_PC;
            refReqPc       = TB_RESET_PC;
            refOutstanding = 0;
            refDiscard     = 0;
            refKnown       = 1;
        end else if (refKnown) begin
            if (redirect_i) begin
                refQ.delete();
                refNextPc = redirect_pc_i & 32'hFFFF_FFFC;
                if (refOutstanding && rv) refOutstanding = 0;
                else if (refOutstanding) refDiscard = 1;
            end else begin
                if (doPop) refQ.pop_front();
                if (doPush) begin
                    e.pc    = refReqPc;
                    e.instr = imem_rdata_i;
                    refQ.push_back(e);
                end
                if (refOutstanding && rv) begin
                    refOutstanding = 0;
                    refDiscard     = 0;
                end
                if (doIssue) begin
                    refOutstanding = 1;
                    refDiscard     = 0;
                    refReqPc       = refNextPc;
                    refNextPc      = refNextPc + 32'd4;
                end
            end
        end
        cycleNo++;
    endtask

    task automatic runCycle(input bit assertReset);
        applyStimulus(assertReset);
        stepModel();
    endtask

    task automatic runPhase(input int n, input int lat, input int sPct, input int rPct);
        latency  = lat;
        stallPct = sPct;
        redirPct = rPct;
        for (int i = 0; i < n; i++) runCycle(0);
    endtask

    initial begin
        reset_n       = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;

        latency = 1;
        repeat (3) runCycle(1);
        checkOutput("reset_valid", instr_valid_o, 1'b0);
        checkOutput("reset_instr", instr_o, NOP_INSTR);
        checkOutput("reset_req", imem_req_o, 1'b0);

        // Back-to-back fetches from RESET_PC with single-cycle memory.
        reqLog.delete();
        for (int i = 0; i < 6; i++) begin
            runCycle(0);
            if (i == 1) checkOutput("valid_before_first_resp", instr_valid_o, 1'b0);
            if (i == 2) begin
                checkOutput("first_valid", instr_valid_o, 1'b1);
                checkOutput("first_pc", pc_o, 32'h0000_0100);
            end
        end
        checkOutput("req_count_l1", reqLog.size() >= 3, 1'b1);
        if (reqLog.size() >= 3) begin
            checkOutput("req0_addr", reqLog[0], 32'h0000_0100);
            checkOutput("req1_addr", reqLog[1], 32'h0000_0104);
            checkOutput("req2_addr", reqLog[2], 32'h0000_0108);
        end

        runPhase(40, 3, 0, 0);
        runPhase(60, 1, 30, 0);
        runPhase(80, 2, 20, 10);

        // Address wrap: redirect to the last word, then the next fetch must be word 0.
        runPhase(5, 1, 0, 0);
        forceRedirect = 1;
        forceTarget   = 32'hFFFF_FFFF;
        reqLog.delete();
        runPhase(8, 1, 0, 0);
        checkOutput("wrap_req_count", reqLog.size() >= 2, 1'b1);
        if (reqLog.size() >= 2) begin
            checkOutput("wrap_first", reqLog[0], 32'hFFFF_FFFC);
            checkOutput("wrap_next", reqLog[1], 32'h0000_0000);
        end

        for (int p = 0; p < 30; p++) begin
            runPhase($urandom_range(20, 80), $urandom_range(1, 4),
                     $urandom_range(0, 40), $urandom_range(0, 15));
            if (p % 7 == 3) begin
                repeat ($urandom_range(1, 3)) runCycle(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
